// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner: drives one column low at a time, debounces a single-key
// press on the synchronized rows, reports it as row*4+col and tracks release.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  localparam logic [15:0] DwellMax = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DebCnt   = 4'(DEBOUNCE);

  state_e      state_q, state_d;
  logic [3:0]  rs_meta_q, rs_q;
  logic [15:0] dwell_q, dwell_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  rel_q, rel_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        tick;
  logic        one_low;
  logic [1:0]  row_idx;

  // Only a single low row is a legal key; anything else is idle or ghosting.
  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rs_q)
      4'hE:    row_idx = 2'd0;
      4'hD:    row_idx = 2'd1;
      4'hB:    row_idx = 2'd2;
      4'h7:    row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    tick    = (dwell_q == DwellMax);
    state_d = state_q;
    dwell_d = dwell_q;
    col_d   = col_q;
    match_d = match_q;
    rel_d   = rel_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;

    if (!scan_en) begin
      state_d = StScan;
      dwell_d = '0;
      col_d   = '0;
      match_d = '0;
      rel_d   = '0;
    end else begin
      dwell_d = tick ? '0 : dwell_q + 16'd1;
      if (tick) begin
        case (state_q)
          StScan: begin
            if (one_low) begin
              pat_d   = rs_q;
              match_d = 4'd1;
              if (DebCnt == 4'd1) begin
                state_d = StHeld;
                code_d  = {row_idx, col_q};
                valid_d = 1'b1;
                rel_d   = '0;
              end else begin
                state_d = StDebounce;
              end
            end else begin
              col_d = col_q + 2'd1;
            end
          end
          StDebounce: begin
            if (rs_q == pat_q) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == DebCnt) begin
                state_d = StHeld;
                code_d  = {row_idx, col_q};
                valid_d = 1'b1;
                rel_d   = '0;
              end
            end else begin
              state_d = StScan;
              col_d   = col_q + 2'd1;
            end
          end
          StHeld: begin
            if (rs_q == 4'hF) begin
              rel_d = rel_q + 4'd1;
              if (rel_q + 4'd1 == DebCnt) begin
                state_d = StScan;
                col_d   = col_q + 2'd1;
                rel_d   = '0;
              end
            end else begin
              rel_d = '0;
            end
          end
          default: state_d = StScan;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta_q <= 4'hF;
      rs_q      <= 4'hF;
      state_q   <= StScan;
      dwell_q   <= '0;
      col_q     <= '0;
      match_q   <= '0;
      rel_q     <= '0;
      pat_q     <= 4'hF;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      rs_meta_q <= row_in;
      rs_q      <= rs_meta_q;
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      col_q     <= col_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      pat_q     <= pat_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign col_out   = scan_en ? ~(4'b0001 << col_q) : 4'hF;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == StHeld);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model closes rows against the driven
// columns, and a rule-level reference model is compared against the outputs every cycle.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_en  (scan_en),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: modes 0=scanning, 1=confirming press, 2=key down.
  int m_s1, m_s2, m_cnt, m_col, m_mode, m_match, m_rel, m_pat, m_code, m_valid;

  task automatic model_accept(input int row);
    m_code  = row * 4 + m_col;
    m_valid = 1;
    m_mode  = 2;
    m_rel   = 0;
  endtask

  task automatic model_step();
    int smp, lows, row;
    bit tk;
    if (!rst_n) begin
      m_s1 = 15; m_s2 = 15; m_cnt = 0; m_col = 0; m_mode = 0;
      m_match = 0; m_rel = 0; m_pat = 15; m_code = 0; m_valid = 0;
      return;
    end
    smp     = m_s2;
    m_s2    = m_s1;
    m_s1    = int'(row_in);
    m_valid = 0;
    tk      = (m_cnt == SCAN_DIV - 1);
    if (!scan_en) begin
      m_mode = 0; m_col = 0; m_cnt = 0; m_match = 0; m_rel = 0;
      return;
    end
    m_cnt = tk ? 0 : m_cnt + 1;
    if (!tk) return;
    lows = 0;
    row  = 0;
    for (int r = 0; r < 4; r++)
      if (((smp >> r) & 1) == 0) begin
        lows++;
        row = r;
      end
    if (m_mode == 0) begin
      if (lows == 1) begin
        m_pat   = smp;
        m_match = 1;
        if (m_match >= DEBOUNCE) model_accept(row);
        else m_mode = 1;
      end else m_col = (m_col + 1) % 4;
    end else if (m_mode == 1) begin
      if (smp == m_pat) begin
        m_match++;
        if (m_match >= DEBOUNCE) model_accept(row);
      end else begin
        m_mode = 0;
        m_col  = (m_col + 1) % 4;
      end
    end else begin
      if (smp == 15) begin
        m_rel++;
        if (m_rel >= DEBOUNCE) begin
          m_mode = 0;
          m_col  = (m_col + 1) % 4;
          m_rel  = 0;
        end
      end else m_rel = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  always @(negedge clk) begin
    check("col_out", 16'(col_out), scan_en ? 16'(4'hF ^ (4'h1 << m_col)) : 16'hF);
    check("key_code", 16'(key_code), 16'(m_code));
    check("key_valid", 16'(key_valid), 16'(m_valid));
    check("key_held", 16'(key_held), 16'(m_mode == 2));
  end

  always @(posedge clk) if (key_valid === 1'b1) pulses++;

  task automatic wait_held(input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_held === lvl) break;
    end
    check(name, 16'(key_held), 16'(lvl));
  endtask

  initial begin
    logic [3:0] idle_exp;
    rst_n   = 1'b0;
    scan_en = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 16'(col_out), 16'hE);
    check("rst_code", 16'(key_code), 16'h0);
    check("rst_valid", 16'(key_valid), 16'h0);
    check("rst_held", 16'(key_held), 16'h0);
    @(posedge clk); #1 scan_en = 1'b0;
    @(negedge clk);
    check("rst_dis_col", 16'(col_out), 16'hF);
    @(posedge clk); #1 scan_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle scan: E,D,B,7 each for 4 cycles, then back to E.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      idle_exp = 4'hF ^ (4'h1 << ((i / 4) % 4));
      check("idle_col", 16'(col_out), 16'(idle_exp));
    end
    check("idle_pulses", 16'(pulses), 16'd0);

    // Key 9: row 2 on column 1.
    @(posedge clk); #1 pressed[9] = 1'b1;
    wait_held(1'b1, 60, "k9_held");
    repeat (8) @(negedge clk);
    check("k9_code", 16'(key_code), 16'd9);
    check("k9_col", 16'(col_out), 16'hD);
    check("k9_still_held", 16'(key_held), 16'd1);
    check("k9_pulses", 16'(pulses), 16'd1);

    @(posedge clk); #1 pressed[9] = 1'b0;
    wait_held(1'b0, 60, "k9_release");
    check("rel_code", 16'(key_code), 16'd9);
    check("rel_col", 16'(col_out), 16'hB);

    // Bounce on key 6 (row 1, column 2): low for one tick only.
    @(posedge clk); #1 pressed[6] = 1'b1;
    repeat (3) @(posedge clk);
    #1 pressed[6] = 1'b0;
    @(negedge clk);
    check("bounce_frozen", 16'(col_out), 16'hB);
    repeat (5) @(negedge clk);
    check("bounce_col", 16'(col_out), 16'h7);
    check("bounce_pulses", 16'(pulses), 16'd1);
    check("bounce_held", 16'(key_held), 16'd0);

    // Ghosting: rows 0 and 3 low together on column 0.
    @(posedge clk); #1 pressed[0] = 1'b1; pressed[12] = 1'b1;
    repeat (40) @(negedge clk);
    check("ghost_pulses", 16'(pulses), 16'd1);
    check("ghost_held", 16'(key_held), 16'd0);
    @(posedge clk); #1 pressed = '0;

    // scan_en drop while held: key_held falls one cycle later, code kept.
    @(posedge clk); #1 pressed[9] = 1'b1;
    wait_held(1'b1, 80, "k9b_held");
    repeat (3) @(negedge clk);
    check("k9b_pulses", 16'(pulses), 16'd2);
    @(posedge clk); #1 scan_en = 1'b0;
    @(negedge clk);
    check("dis_col", 16'(col_out), 16'hF);
    check("dis_held_same", 16'(key_held), 16'd1);
    @(negedge clk);
    check("dis_held_next", 16'(key_held), 16'd0);
    check("dis_code", 16'(key_code), 16'd9);
    @(posedge clk); #1 scan_en = 1'b1;

    // Reset during press confirmation: no pulse, reset values at once.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_out == 4'hD) break;
    end
    check("deb_reach", 16'(col_out), 16'hD);
    repeat (4) @(negedge clk);
    check("deb_frozen", 16'(col_out), 16'hD);
    @(posedge clk); #1 rst_n = 1'b0; scan_en = 1'b0;
    @(negedge clk);
    check("mid_rst_col", 16'(col_out), 16'hF);
    check("mid_rst_code", 16'(key_code), 16'd0);
    check("mid_rst_held", 16'(key_held), 16'd0);
    check("mid_rst_valid", 16'(key_valid), 16'd0);
    @(posedge clk); #1 scan_en = 1'b1;
    @(negedge clk);
    check("mid_rst_col_en", 16'(col_out), 16'hE);
    @(posedge clk); #1 rst_n = 1'b1; pressed = '0;
    repeat (12) @(negedge clk);
    check("final_pulses", 16'(pulses), 16'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
